// File: rtl/ws2812b_arbiter_pkg.sv
// Shared sizing, state encoding and owner codes for the WS2812B
// two-requester colour-write arbiter.
package ws2812b_arbiter_pkg;

    localparam int LED_W            = 8;
    localparam int RGB_W            = 24;
    localparam int DEF_NUM_LEDS     = 28;
    localparam int DEF_LOCK_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_R0   = 2'b01;
    localparam logic [1:0] OWNER_R1   = 2'b10;

endpackage

// File: rtl/ws2812b_rr_pick.sv
// Two-way round-robin selector; remembers which requester was granted last.
module ws2812b_rr_pick (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic any,
    output logic pick1
);

    logic last1;

    assign any   = req0 | req1;
    // On a tie requester 1 wins only if requester 0 was served last.
    assign pick1 = req1 & (~req0 | ~last1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last1 <= 1'b1;
        end else if (take && any) begin
            last1 <= pick1;
        end
    end

endmodule

// File: rtl/ws2812b_arbiter.sv
// Arbitrates two colour-write requesters onto one WS2812B LED driver port,
// with optional grant locking for bursts and a forced release on idle lock.
module ws2812b_arbiter
    import ws2812b_arbiter_pkg::*;
#(
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    input  logic             r1_valid,
    output logic             r0_ready,
    output logic             r1_ready,
    input  logic             r0_lock,
    input  logic             r1_lock,
    input  logic [LED_W-1:0] r0_led_num,
    input  logic [LED_W-1:0] r1_led_num,
    input  logic [RGB_W-1:0] r0_rgb,
    input  logic [RGB_W-1:0] r1_rgb,
    output logic             write,
    output logic [LED_W-1:0] led_num,
    output logic [RGB_W-1:0] rgb_data,
    output logic [1:0]       owner,
    output logic             err_range,
    output logic             err_timeout
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    state_t             state;
    logic [CNT_W-1:0]   idle_cnt;
    logic               sel_valid;
    logic               sel_lock;
    logic [LED_W-1:0]   sel_led;
    logic [RGB_W-1:0]   sel_rgb;
    logic               xfer;
    logic               in_range;
    logic               timeout_hit;
    logic               pick_any;
    logic               pick1;

    assign r0_ready = (state == OWN0);
    assign r1_ready = (state == OWN1);

    always_comb begin
        owner = OWNER_NONE;
        if (state == OWN0) owner = OWNER_R0;
        else if (state == OWN1) owner = OWNER_R1;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_lock  = 1'b0;
        sel_led   = r0_led_num;
        sel_rgb   = r0_rgb;
        if (state == OWN0) begin
            sel_valid = r0_valid;
            sel_lock  = r0_lock;
        end else if (state == OWN1) begin
            sel_valid = r1_valid;
            sel_lock  = r1_lock;
            sel_led   = r1_led_num;
            sel_rgb   = r1_rgb;
        end
    end

    assign xfer        = sel_valid;
    assign in_range    = sel_led < LED_W'(NUM_LEDS);
    assign timeout_hit = idle_cnt == CNT_W'(LOCK_TIMEOUT - 1);

    ws2812b_rr_pick u_pick (
        .clk   (clk),
        .reset (reset),
        .req0  (r0_valid),
        .req1  (r1_valid),
        .take  (state == IDLE),
        .any   (pick_any),
        .pick1 (pick1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idle_cnt    <= '0;
            write       <= 1'b0;
            led_num     <= '0;
            rgb_data    <= '0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            write       <= 1'b0;
            err_range   <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= '0;
                    if (pick_any) state <= pick1 ? OWN1 : OWN0;
                end
                OWN0, OWN1: begin
                    if (xfer) begin
                        idle_cnt  <= '0;
                        write     <= in_range;
                        err_range <= !in_range;
                        if (in_range) begin
                            led_num  <= sel_led;
                            rgb_data <= sel_rgb;
                        end
                        if (!sel_lock) state <= IDLE;
                    end else if (!sel_lock) begin
                        state <= IDLE;
                    end else if (timeout_hit) begin
                        // Lock held with nothing to send for too long.
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_arbiter.sv
// Directed and randomized checks of ws2812b_arbiter against a
// burst-level reference model of grant order, data and timing.
module tb_ws2812b_arbiter;

    localparam int NL = 28;
    localparam int LT = 1024;

    typedef struct packed {
        logic       lock;
        logic [7:0] led;
        logic [23:0] rgb;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r1_valid, r0_lock, r1_lock;
    logic [7:0]  r0_led_num, r1_led_num;
    logic [23:0] r0_rgb, r1_rgb;
    logic        r0_ready, r1_ready, write, err_range, err_timeout;
    logic [7:0]  led_num;
    logic [23:0] rgb_data;
    logic [1:0]  owner;

    int total = 0;
    int passed = 0;
    int failed = 0;
    int cyc = 0;
    int both_ready = 0;
    bit mon_en = 1'b0;
    int n, s, b, held;
    bit h0, h1;
    logic [7:0]  rl;
    logic [23:0] rc;
    beat_t bt;
    beat_t q0[$];
    beat_t q1[$];
    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    ws2812b_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .r0_valid    (r0_valid),
        .r1_valid    (r1_valid),
        .r0_ready    (r0_ready),
        .r1_ready    (r1_ready),
        .r0_lock     (r0_lock),
        .r1_lock     (r1_lock),
        .r0_led_num  (r0_led_num),
        .r1_led_num  (r1_led_num),
        .r0_rgb      (r0_rgb),
        .r1_rgb      (r1_rgb),
        .write       (write),
        .led_num     (led_num),
        .rgb_data    (rgb_data),
        .owner       (owner),
        .err_range   (err_range),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ev(input logic [1:0] k, input int c,
                                       input logic [7:0] l, input logic [23:0] r);
        logic [15:0] c16;
        c16 = c[15:0];
        return {14'd0, k, c16, l, r};
    endfunction

    always @(negedge clk) begin
        if (r0_ready && r1_ready) both_ready <= both_ready + 1;
        if (mon_en && (write || err_range || err_timeout))
            obs_q.push_back(ev({err_range | err_timeout, write | err_timeout}, cyc,
                               write ? led_num : 8'd0, write ? rgb_data : 24'd0));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic l, input logic [7:0] num, input logic [23:0] c);
        r0_valid = v; r0_lock = l; r0_led_num = num; r0_rgb = c;
    endtask

    task automatic drive1(input logic v, input logic l, input logic [7:0] num, input logic [23:0] c);
        r1_valid = v; r1_lock = l; r1_led_num = num; r1_rgb = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive0(1'b0, 1'b0, 8'd0, 24'd0);
        drive1(1'b0, 1'b0, 8'd0, 24'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [63:0] outs();
        return 64'({owner, write, led_num, rgb_data, err_range, err_timeout, r0_ready, r1_ready});
    endfunction

    initial begin
        do_reset();
        check("reset_outs", outs(), 64'd0);

        // single non-locked beat from requester 0
        drive0(1'b1, 1'b0, 8'd5, 24'h00FF00);
        @(negedge clk);
        check("t1_owner", 64'(owner), 64'd1);
        check("t1_ready", 64'({r0_ready, r1_ready}), 64'd2);
        check("t1_no_early_write", 64'(write), 64'd0);
        @(negedge clk);
        check("t1_write", 64'({write, led_num, rgb_data}), 64'({1'b1, 8'd5, 24'h00FF00}));
        check("t1_release", 64'(owner), 64'd0);
        r0_valid = 1'b0;
        @(negedge clk);
        check("t1_single_pulse", 64'(write), 64'd0);

        // simultaneous requests alternate
        do_reset();
        drive0(1'b1, 1'b0, 8'd1, 24'h111111);
        drive1(1'b1, 1'b0, 8'd2, 24'h222222);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_owner", 64'(owner), 64'((i % 2 == 1) ? 0 : ((i % 4 == 0) ? 1 : 2)));
            if (i % 2 == 1)
                check("t2_write_led", 64'({write, led_num}), 64'({1'b1, ((i % 4 == 1) ? 8'd1 : 8'd2)}));
        end
        drive0(1'b0, 1'b0, 8'd0, 24'd0);
        drive1(1'b0, 1'b0, 8'd0, 24'd0);
        @(negedge clk);

        // locked 28-beat burst from requester 1 with requester 0 waiting
        do_reset();
        drive1(1'b1, 1'b1, 8'd0, 24'd0);
        @(negedge clk);
        check("t3_grant1", 64'(owner), 64'd2);
        drive0(1'b1, 1'b0, 8'd3, 24'hABCDEF);
        for (int i = 0; i < NL; i++) begin
            drive1(1'b1, i != NL - 1, 8'(i), 24'(i * 32'h010101));
            check("t3_ready", 64'({r0_ready, r1_ready}), 64'd1);
            @(negedge clk);
            check("t3_burst", 64'({write, led_num, rgb_data}),
                  64'({1'b1, 8'(i), 24'(i * 32'h010101)}));
        end
        r1_valid = 1'b0;
        r1_lock = 1'b0;
        @(negedge clk);
        check("t3_grant0", 64'(owner), 64'd1);
        @(negedge clk);
        check("t3_r0_beat", 64'({write, led_num, rgb_data}), 64'({1'b1, 8'd3, 24'hABCDEF}));

        // out-of-range beat
        drive0(1'b1, 1'b0, 8'(NL), 24'h123456);
        @(negedge clk);
        check("t4_owner", 64'(owner), 64'd1);
        @(negedge clk);
        check("t4_err", 64'({write, err_range, owner}), 64'({1'b0, 1'b1, 2'b00}));
        r0_valid = 1'b0;
        @(negedge clk);
        check("t4_err_pulse", 64'({write, err_range}), 64'd0);

        // lock held with nothing to send
        drive1(1'b1, 1'b1, 8'd7, 24'h070707);
        @(negedge clk);
        check("t5_grant1", 64'(owner), 64'd2);
        r1_valid = 1'b0;
        drive0(1'b1, 1'b0, 8'd9, 24'h090909);
        held = 0;
        for (int i = 0; i < 2 * LT; i++) begin
            if (owner != 2'd2) break;
            held++;
            @(negedge clk);
        end
        check("t5_hold_len", 64'(held), 64'(LT));
        check("t5_timeout", 64'({owner, err_timeout, write}), 64'({2'b00, 1'b1, 1'b0}));
        @(negedge clk);
        check("t5_next_r0", 64'({owner, err_timeout}), 64'({2'b01, 1'b0}));
        @(negedge clk);
        check("t5_r0_beat", 64'({write, led_num, rgb_data}), 64'({1'b1, 8'd9, 24'h090909}));
        r0_valid = 1'b0;
        r1_lock = 1'b0;
        @(negedge clk);

        // reset right after a handshake
        drive0(1'b1, 1'b0, 8'd12, 24'h0C0C0C);
        @(negedge clk);
        check("t6_owner", 64'(owner), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        r0_valid = 1'b0;
        #1;
        check("t6_in_reset", outs(), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_after_reset", outs(), 64'd0);
        end

        // randomized bursts on both requesters, checked against burst model
        do_reset();
        s = cyc;
        b = s + 1;
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < 2; r++) begin
                n = $urandom_range(4, 1);
                for (int j = 1; j <= n; j++) begin
                    rl = 8'($urandom_range(31, 0));
                    rc = 24'($urandom);
                    bt.lock = (j != n);
                    bt.led = rl;
                    bt.rgb = rc;
                    if (r == 0) q0.push_back(bt);
                    else q1.push_back(bt);
                    if (rl < 8'(NL)) exp_q.push_back(ev(2'd1, b + j, rl, rc));
                    else exp_q.push_back(ev(2'd2, b + j, 8'd0, 24'd0));
                end
                b += n + 1;
            end
        end
        mon_en = 1'b1;
        for (int t = 0; t < 400; t++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            r0_valid = q0.size() != 0;
            r1_valid = q1.size() != 0;
            if (r0_valid) {r0_lock, r0_led_num, r0_rgb} = q0[0];
            if (r1_valid) {r1_lock, r1_led_num, r1_rgb} = q1[0];
            h0 = r0_valid && r0_ready;
            h1 = r1_valid && r1_ready;
            @(posedge clk);
            if (h0) void'(q0.pop_front());
            if (h1) void'(q1.pop_front());
            @(negedge clk);
        end
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("rand_drained", 64'(q0.size() + q1.size()), 64'd0);
        check("rand_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check("rand_event", (i < obs_q.size()) ? obs_q[i] : 64'hFFFF_FFFF_FFFF_FFFF, exp_q[i]);
        check("never_both_ready", 64'(both_ready), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ws2812b_arbiter.md
WS2812B_ARBITER -- requirements
Module: ws2812b_arbiter

Interface
REQ-001 NUM_LEDS, 28, LEDs in chain; led_num >= NUM_LEDS is out of range.
REQ-002 LOCK_TIMEOUT, 1024, idle cycles a held grant tolerates before forced release.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 r0_valid / r1_valid  input  1  requester has a colour write pending.
REQ-006 r0_ready / r1_ready  output  1  arbiter accepts the beat this cycle.
REQ-007 r0_lock / r1_lock  input  1  requester keeps ownership after the current beat.
REQ-008 r0_led_num / r1_led_num  input  8  target LED index.
REQ-009 r0_rgb / r1_rgb  input  24  GRB colour word.
REQ-010 write  output  1  one-cycle write strobe to the LED driver.
REQ-011 led_num  output  8  driver LED index, valid when write=1.
REQ-012 rgb_data  output  24  driver colour, valid when write=1.
REQ-013 owner  output  2  00 none, 01 requester 0, 10 requester 1.
REQ-014 err_range  output  1  one-cycle pulse, out-of-range beat dropped.
REQ-015 err_timeout  output  1  one-cycle pulse, held grant forcibly released.

Function
REQ-016 FSM states SHALL be IDLE, OWN0, OWN1; owner reflects state (00/01/10).
REQ-017 In IDLE, only one valid: next state OWN of that requester; both valid: grant the requester not served last (round-robin, initial preference requester 0); none: stay IDLE.
REQ-018 rN_ready SHALL be 1 only in OWNN and combinational from state; never asserted in IDLE; never both 1.
REQ-019 A beat transfers when rN_valid and rN_ready are both 1 in the same cycle.
REQ-020 On transfer with in-range led_num: write=1, led_num/rgb_data = captured beat, exactly one cycle later (latency 1, registered outputs).
REQ-021 On transfer with led_num >= NUM_LEDS: write stays 0, err_range=1 one cycle later; handshake still completes.
REQ-022 Release to IDLE when: transfer with rN_lock=0; or rN_valid=0 and rN_lock=0; or timeout.
REQ-023 Transfer with rN_lock=1: remain in OWNN, back-to-back beats at one per cycle.
REQ-024 Idle counter: cleared on entry to OWNx and on every transfer, increments each OWNx cycle without transfer; at LOCK_TIMEOUT release to IDLE, err_timeout=1 one cycle later.
REQ-025 Last-served marker updates on entry to OWNx, not per beat.
REQ-026 write, err_range, err_timeout SHALL never be high two consecutive cycles unless consecutive transfers/events occur; write and err_range mutually exclusive.
REQ-027 Requester inputs are sampled only when rN_ready=1; changes while not ready have no effect.
REQ-028 From IDLE, first write appears no earlier than two cycles after valid rises (grant cycle + output register).

Reset
REQ-029 Reset SHALL force IDLE, owner=00, write=0, led_num=0, rgb_data=0, err_range=0, err_timeout=0, both ready=0, idle counter 0, last-served = requester 1 (so requester 0 wins first tie).
REQ-030 Reset mid-ownership SHALL abandon the grant; an in-flight beat accepted the cycle before reset SHALL NOT produce write after reset deasserts.

Structure
REQ-031 Shared package holds: state encoding (IDLE/OWN0/OWN1), owner codes, NUM_LEDS default, LED index width (8) and colour width (24).
REQ-032 One sub-module natural: ws2812b_rr_pick (two-way round-robin selector with last-served register); rest flat.

Verification
REQ-033 Reset, then r0_valid=1, r0_lock=0, led_num=5, rgb=0x00FF00 -> owner=01 next cycle, r0_ready=1, write=1 with led 5 / 0x00FF00 one cycle after handshake, owner=00 after.
REQ-034 r0 and r1 valid simultaneously from reset, lock=0, repeated -> grants alternate 0,1,0,1; no cycle with both ready.
REQ-035 r1 locked burst of 28 beats led 0..27 while r0_valid=1 -> 28 consecutive write pulses, r0_ready=0 throughout, r0 granted right after r1 drops lock.
REQ-036 r0 beat led_num=28 (NUM_LEDS=28) -> handshake completes, write=0, err_range=1 for one cycle.
REQ-037 r1 takes grant with lock=1 then valid=0 for LOCK_TIMEOUT cycles -> err_timeout pulse, owner=00, pending r0 granted next.
REQ-038 Assert reset one cycle after r0 handshake -> write stays 0, all outputs at reset values.
